// File: rtl/bus_dma_master_pkg.sv
// Shared bus definitions for the DMA initiator and the bus responders.
// Provides size/rw encodings, FSM state codes, the request payload struct
// and the unit-size helper.
package bus_dma_master_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_RD_REQ = 3'd1;
    localparam logic [ST_W-1:0] ST_RD_GAP = 3'd2;
    localparam logic [ST_W-1:0] ST_WR_REQ = 3'd3;
    localparam logic [ST_W-1:0] ST_WR_GAP = 3'd4;
    localparam logic [ST_W-1:0] ST_FINISH = 3'd5;

    // Request-side bus payload, held stable for the life of a request
    typedef struct packed {
        logic        req;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // Bytes per transfer unit; 0 for the illegal encoding
    function automatic logic [2:0] unit_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: unit_bytes = 3'd1;
            SZ_HALF: unit_bytes = 3'd2;
            SZ_WORD: unit_bytes = 3'd4;
            default: unit_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/bus_dma_master_timer.sv
// bus_req_timer: per-request timeout counter.
// Ports: clk, rst_n (async active-low), load (hold count at zero),
//        expired_c (count has reached TIMEOUT-1 cycles of waiting).
module bus_req_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired_c = (count_q == CNT_W'(TIMEOUT - 1));

    // Counts while not loaded; saturates at the expire value
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (!expired_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_dma_master.sv
// bus_dma_master: bus initiator copying len bytes from src_addr to dst_addr
// in byte/half/word units via alternating read and write requests.
// Ports: clk, reset (async active-low); start/abort/src_addr/dst_addr/len/
//        xfer_size config; busy/done/error status; mem_* request/response bus.
module bus_dma_master
    import bus_dma_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       xfer_size,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      mem_address,
    output logic             mem_rw_req,
    output logic             mem_rw,
    output logic [31:0]      mem_write_data,
    output logic [1:0]       mem_size,
    input  logic [31:0]      mem_read_data,
    input  logic             mem_rec
);

    logic [ST_W-1:0]  state_q, state_d;
    bus_req_t         req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             abort_pend_q, abort_pend_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      data_q, data_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic [2:0]       unit_c;
    logic [2:0]       start_unit_c;
    logic [1:0]       start_mask_c;
    logic             cfg_bad_c;
    logic [LEN_W-1:0] rem_next_c;
    logic             timer_load_c;
    logic             expired_c;

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign mem_address    = req_q.addr;
    assign mem_rw_req     = req_q.req;
    assign mem_rw         = req_q.rw;
    assign mem_write_data = req_q.wdata;
    assign mem_size       = req_q.size;

    // Latched size drives the unit; start-time size drives the legality check
    assign unit_c       = unit_bytes(req_q.size);
    assign rem_next_c   = rem_q - LEN_W'(unit_c);
    assign start_unit_c = unit_bytes(xfer_size);
    assign start_mask_c = 2'(start_unit_c - 3'd1);
    assign cfg_bad_c    = (xfer_size == SZ_ILLEGAL) || (len == '0)
                       || ((len[1:0] & start_mask_c) != 2'b00)
                       || ((src_addr[1:0] & start_mask_c) != 2'b00)
                       || ((dst_addr[1:0] & start_mask_c) != 2'b00);

    // Timer runs only while a request is outstanding
    assign timer_load_c = (state_q != ST_RD_REQ) && (state_q != ST_WR_REQ);

    bus_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .load      (timer_load_c),
        .expired_c (expired_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        abort_pend_d = (state_q == ST_IDLE) ? 1'b0 : (abort_pend_q | abort);
        src_d        = src_q;
        dst_d        = dst_q;
        data_d       = data_q;
        rem_d        = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    req_d.size = xfer_size;
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    rem_d      = len;
                    busy_d     = 1'b1;
                    if (cfg_bad_c) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        error_d    = 1'b0;
                        req_d.req  = 1'b1;
                        req_d.rw   = RW_READ;
                        req_d.addr = src_addr;
                        state_d    = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (mem_rec) begin
                    data_d    = mem_read_data;
                    req_d.req = 1'b0;
                    state_d   = ST_RD_GAP;
                end else if (expired_c) begin
                    req_d.req = 1'b0;
                    error_d   = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
            ST_RD_GAP: begin
                req_d.req   = 1'b1;
                req_d.rw    = RW_WRITE;
                req_d.addr  = dst_q;
                req_d.wdata = data_q;
                state_d     = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (mem_rec) begin
                    req_d.req = 1'b0;
                    state_d   = ST_WR_GAP;
                end else if (expired_c) begin
                    req_d.req = 1'b0;
                    error_d   = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
            ST_WR_GAP: begin
                src_d = src_q + 32'(unit_c);
                dst_d = dst_q + 32'(unit_c);
                rem_d = rem_next_c;
                // Abort only takes effect here, after a full read+write pair
                if ((rem_next_c == '0) || abort_pend_q || abort) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    req_d.req  = 1'b1;
                    req_d.rw   = RW_READ;
                    req_d.addr = src_q + 32'(unit_c);
                    state_d    = ST_RD_REQ;
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                req_d.req = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            data_q       <= '0;
            rem_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            abort_pend_q <= abort_pend_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            data_q       <= data_d;
            rem_q        <= rem_d;
        end
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master with a latency-programmable responder.
module tb_bus_dma_master;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned LEN_W   = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic [1:0]       xfer_size;
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      mem_address;
    logic             mem_rw_req;
    logic             mem_rw;
    logic [31:0]      mem_write_data;
    logic [1:0]       mem_size;
    logic [31:0]      mem_read_data;
    logic             mem_rec;

    int checks = 0;
    int errors = 0;

    // Responder / monitor state (written only by the responder process)
    int          resp_lat = 2;   // 0 = never respond
    int          resp_cnt;
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_rw[$];
    logic [1:0]  log_size[$];
    int          gaps[$];
    int          high_run = 0;
    int          low_run = 0;
    int          last_high = 0;
    int          done_cnt = 0;
    int          req_cnt = 0;
    bit          seen_req = 0;

    bus_dma_master #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len            (len),
        .xfer_size      (xfer_size),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_address    (mem_address),
        .mem_rw_req     (mem_rw_req),
        .mem_rw         (mem_rw),
        .mem_write_data (mem_write_data),
        .mem_size       (mem_size),
        .mem_read_data  (mem_read_data),
        .mem_rec        (mem_rec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
    endfunction

    // Responder: acknowledges each request resp_lat cycles after it rises
    always @(negedge clk) begin
        if (!reset) begin
            mem_rec       = 1'b0;
            mem_read_data = '0;
            resp_cnt      = 0;
        end else begin
            if (!busy) seen_req = 0;
            if (done) done_cnt++;
            if (mem_rw_req) begin
                if (high_run == 0) begin
                    req_cnt++;
                    if (seen_req) gaps.push_back(low_run);
                    seen_req = 1;
                end
                high_run++;
                low_run = 0;
                if (mem_rec) begin
                    mem_rec = 1'b0;
                end else begin
                    resp_cnt++;
                    if (resp_lat != 0 && resp_cnt == resp_lat) begin
                        mem_rec       = 1'b1;
                        mem_read_data = rd_val(mem_address);
                        log_addr.push_back(mem_address);
                        log_wdata.push_back(mem_write_data);
                        log_rw.push_back(mem_rw);
                        log_size.push_back(mem_size);
                    end
                end
            end else begin
                mem_rec  = 1'b0;
                resp_cnt = 0;
                if (high_run > 0) last_high = high_run;
                high_run = 0;
                low_run++;
            end
        end
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input logic [1:0] z);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len       = l;
        xfer_size = z;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int max, output bit ok, output int cyc);
        ok  = 0;
        cyc = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            #1;
            cyc = i + 1;
            if (done_cnt > base) ok = 1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; xfer_size = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", error); end
        checks++; if (mem_rw_req !== 1'b0 || mem_rw !== 1'b0) begin errors++; $display("FAIL rst_req got req=%b rw=%b exp 0 0", mem_rw_req, mem_rw); end
        checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_address); end
        checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", mem_write_data); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word_copy;
        int db, lb, gb, cyc;
        bit ok;
        resp_lat = 2;
        db = done_cnt; lb = log_addr.size(); gb = gaps.size();
        do_start(32'h100, 32'h200, 16'd8, 2'b10);
        wait_done(db, 100, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL word_done got none in %0d cycles exp pulse", cyc); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (log_addr.size() - lb != 4) begin
            errors++; $display("FAIL word_count got %0d exp 4", log_addr.size() - lb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] ea, ed;
                logic w;
                w  = (i % 2) == 1;
                ea = w ? 32'h200 + 32'(4 * (i / 2)) : 32'h100 + 32'(4 * (i / 2));
                ed = rd_val(32'h100 + 32'(4 * (i / 2)));
                checks++;
                if (log_rw[lb+i] !== w || log_addr[lb+i] !== ea || (w && log_wdata[lb+i] !== ed)) begin
                    errors++;
                    $display("FAIL word_txn%0d got rw=%b addr=%h data=%h exp rw=%b addr=%h data=%h",
                             i, log_rw[lb+i], log_addr[lb+i], log_wdata[lb+i], w, ea, ed);
                end
            end
        end
        checks++;
        if (gaps.size() - gb != 3) begin
            errors++; $display("FAIL word_gapcount got %0d exp 3", gaps.size() - gb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gaps[gb+i] != 1) begin errors++; $display("FAIL word_gap%0d got %0d exp 1", i, gaps[gb+i]); end
            end
        end
        checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL word_donecnt got %0d exp 1", done_cnt - db); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL word_error got %b exp 0", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL word_busy got %b exp 0", busy); end
    endtask

    task automatic test_byte_copy;
        int db, lb, cyc;
        bit ok;
        resp_lat = 1;
        db = done_cnt; lb = log_addr.size();
        do_start(32'h3, 32'h7, 16'd3, 2'b00);
        wait_done(db, 100, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL byte_done got none in %0d cycles exp pulse", cyc); end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (log_addr.size() - lb != 6) begin
            errors++; $display("FAIL byte_count got %0d exp 6", log_addr.size() - lb);
        end else begin
            for (int i = 0; i < 6; i++) begin
                logic [31:0] ea, ed;
                logic w;
                w  = (i % 2) == 1;
                ea = w ? 32'h7 + 32'(i / 2) : 32'h3 + 32'(i / 2);
                ed = rd_val(32'h3 + 32'(i / 2));
                checks++;
                if (log_rw[lb+i] !== w || log_addr[lb+i] !== ea || log_size[lb+i] !== 2'b00
                    || (w && log_wdata[lb+i] !== ed)) begin
                    errors++;
                    $display("FAIL byte_txn%0d got rw=%b addr=%h size=%b data=%h exp rw=%b addr=%h size=00 data=%h",
                             i, log_rw[lb+i], log_addr[lb+i], log_size[lb+i], log_wdata[lb+i], w, ea, ed);
                end
            end
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL byte_error got %b exp 0", error); end
    endtask

    task automatic test_illegal;
        int db, rb, cyc;
        bit ok;
        db = done_cnt; rb = req_cnt;
        do_start(32'h100, 32'h200, 16'd6, 2'b10);
        wait_done(db, 10, ok, cyc);
        checks++; if (!ok || cyc > 2) begin errors++; $display("FAIL illegal_done got ok=%0b after %0d cycles exp within 2", ok, cyc); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_cnt != rb) begin errors++; $display("FAIL illegal_req got %0d requests exp 0", req_cnt - rb); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal_error got %b exp 1", error); end
        checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL illegal_donecnt got %0d exp 1", done_cnt - db); end
    endtask

    task automatic test_timeout;
        int db, rb, cyc;
        bit ok;
        resp_lat = 0;
        db = done_cnt; rb = req_cnt;
        do_start(32'h10, 32'h20, 16'd4, 2'b10);
        wait_done(db, 60, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_done got none in %0d cycles exp pulse", cyc); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (last_high != 16) begin errors++; $display("FAIL timeout_high got %0d cycles exp 16", last_high); end
        checks++; if (req_cnt - rb != 1) begin errors++; $display("FAIL timeout_reqs got %0d exp 1", req_cnt - rb); end
        checks++; if (mem_rw_req !== 1'b0) begin errors++; $display("FAIL timeout_req_low got %b exp 0", mem_rw_req); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error got %b exp 1", error); end
        resp_lat = 2;
    endtask

    task automatic test_abort;
        int db, lb, cyc;
        bit ok, hit;
        resp_lat = 3;
        db = done_cnt; lb = log_addr.size();
        hit = 0;
        do_start(32'h1000, 32'h2000, 16'd16, 2'b10);
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (mem_rw_req && !mem_rw && (log_addr.size() - lb == 2)) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL abort_2nd_read got none exp outstanding read"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(db, 100, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL abort_done got none in %0d cycles exp pulse", cyc); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (log_addr.size() - lb != 4) begin
            errors++; $display("FAIL abort_count got %0d exp 4", log_addr.size() - lb);
        end else begin
            checks++;
            if (log_rw[lb+3] !== 1'b1 || log_addr[lb+3] !== 32'h2004 || log_wdata[lb+3] !== rd_val(32'h1004)) begin
                errors++;
                $display("FAIL abort_last_write got rw=%b addr=%h data=%h exp rw=1 addr=00002004 data=%h",
                         log_rw[lb+3], log_addr[lb+3], log_wdata[lb+3], rd_val(32'h1004));
            end
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL abort_error got %b exp 0", error); end
        checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL abort_donecnt got %0d exp 1", done_cnt - db); end
    endtask

    task automatic test_reset_mid;
        int db, lb, cyc;
        bit ok, hit;
        resp_lat = 4;
        hit = 0;
        do_start(32'h100, 32'h200, 16'd8, 2'b10);
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (mem_rw_req && mem_rw) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rmid_wr_req got none exp write request"); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (mem_rw_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b exp 0", mem_rw_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        resp_lat = 1;
        db = done_cnt; lb = log_addr.size();
        do_start(32'h40, 32'h80, 16'd8, 2'b10);
        wait_done(db, 100, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_done got none in %0d cycles exp pulse", cyc); end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (log_addr.size() - lb != 4) begin
            errors++; $display("FAIL rmid_count got %0d exp 4", log_addr.size() - lb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] ea, ed;
                logic w;
                w  = (i % 2) == 1;
                ea = w ? 32'h80 + 32'(4 * (i / 2)) : 32'h40 + 32'(4 * (i / 2));
                ed = rd_val(32'h40 + 32'(4 * (i / 2)));
                checks++;
                if (log_rw[lb+i] !== w || log_addr[lb+i] !== ea || (w && log_wdata[lb+i] !== ed)) begin
                    errors++;
                    $display("FAIL rmid_txn%0d got rw=%b addr=%h data=%h exp rw=%b addr=%h data=%h",
                             i, log_rw[lb+i], log_addr[lb+i], log_wdata[lb+i], w, ea, ed);
                end
            end
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rmid_error got %b exp 0", error); end
    endtask

    initial begin
        test_reset();
        test_word_copy();
        test_byte_copy();
        test_illegal();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_dma_master.md
Name: bus_dma_master

Overview:
Memory-bus initiator that copies a block of bytes, halfwords or words from a source address to a destination address. It drives the same request/valid bus protocol the CPU drives toward the memory, SDRAM and peripheral responders, acting as the initiator end of that protocol. It is configured and started by a peripheral register block and reports busy, done and error. A top-level arbiter grants it the bus; this block assumes ownership while busy.

Parameters:
TIMEOUT, 1024, cycles to wait for data_valid per request before aborting with error
LEN_W, 16, width of the byte-length field

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latch config and begin (ignored while busy)
abort  input  1  stop at next request boundary
src_addr  input  32  source byte address
dst_addr  input  32  destination byte address
len  input  LEN_W  byte count to copy
xfer_size  input  2  unit: 00 byte, 01 half, 10 word (11 illegal)
busy  output  1  transfer in progress
done  output  1  one-cycle pulse on completion, abort or error
error  output  1  sticky; cleared by next accepted start
mem_address  output  32  bus address
mem_rw_req  output  1  request strobe
mem_rw  output  1  1 = write, 0 = read
mem_write_data  output  32  write data
mem_size  output  2  mirrors xfer_size
mem_read_data  input  32  read data from responder
mem_rec  input  1  responder data_valid / write-accepted

Behaviour:
- Reset (async, low): state IDLE; busy, done, mem_rw_req, mem_rw = 0; mem_address, mem_write_data = 0; error = 0; counters cleared. Reset mid-transfer drops mem_rw_req immediately; no partial write is retried.
- Handshake: address, rw, size and write_data are set in the same cycle rw_req rises and held stable until the cycle mem_rec = 1 is sampled. rw_req then deasserts for exactly one cycle (GAP) before any new request. mem_rec while rw_req = 0 is ignored.
- States: IDLE -> RD_REQ -> RD_GAP -> WR_REQ -> WR_GAP -> (RD_REQ | FINISH) -> IDLE.
- IDLE: on start, latch src, dst, len and size. Illegal config (size = 11, len = 0, len not a multiple of unit, or src/dst misaligned to unit) -> FINISH with error = 1 and no bus activity.
- RD_REQ: rw = 0, address = src pointer. On mem_rec, capture mem_read_data into the data register, then go to RD_GAP.
- WR_REQ: rw = 1, address = dst pointer, write_data = captured data unmodified (responders handle lane placement by size). On mem_rec, go to WR_GAP.
- WR_GAP: advance src and dst by the unit (1/2/4) and decrement remaining by the unit. If remaining reaches 0 or abort is pending -> FINISH, else -> RD_REQ.
- Pointers are 32-bit and wrap modulo 2^32 with no error.
- Timeout: a cycle counter resets on each request entry. If it reaches TIMEOUT with no mem_rec, drop rw_req, set error, go to FINISH.
- abort: sampled any cycle while busy and held pending. It never truncates an outstanding request; the current read+write pair completes first. Abort during RD_REQ still finishes the matching write.
- FINISH: done = 1 for one cycle, busy = 0 next cycle, return to IDLE.
- busy = 1 from the cycle after start is accepted until FINISH.
- start while busy is ignored. start and abort together in IDLE: start wins, abort is discarded.
- Throughput: 1 unit per (read latency + write latency + 2 gap cycles).

Decomposition:
- Shared bus package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), rw encoding (RW_READ = 0, RW_WRITE = 1), state enum.
- Package function for unit bytes from size; responders reuse it.
- One natural sub-module: bus_req_timer (loadable timeout counter with expire flag).
- Remaining logic is a single FSM plus datapath registers.

Test Plan:
- Word copy: src = 0x100, dst = 0x200, len = 8, size = 10, responder mem_rec after 2 cycles -> reads 0x100, 0x104 and writes 0x200, 0x204 with matching data; one idle cycle between each request; done pulse once; error = 0.
- Byte copy: src = 0x3, dst = 0x7, len = 3, size = 00 -> 3 read/write pairs at 0x3..0x5 and 0x7..0x9; mem_size = 00 on every request.
- Illegal config: len = 6, size = 10 -> no rw_req ever asserted; done pulse within 2 cycles of start; error = 1.
- Timeout: TIMEOUT = 16, responder never asserts mem_rec -> rw_req high exactly 16 cycles then low; error = 1; done pulse.
- Abort mid-read of the 2nd word in a 4-word copy -> 2nd write completes; no 3rd read issued; done pulse; error = 0.
- Async reset asserted during WR_REQ -> mem_rw_req = 0 and busy = 0 immediately, before the next clk edge; a new start afterwards runs a clean transfer.
